// File: rtl/comp_sched_pkg.sv
// Shared types and helpers for the comp_sched round-robin datapath scheduler.
// The state encoding is fixed so it stays stable in waveforms and debug dumps.
package comp_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Width of an index into n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/comp_sched_rr_pick.sv
// Round-robin pick: the first set req_valid bit searching upward from
// last_grant+1, wrapping modulo N_REQ.
module comp_sched_rr_pick
   import comp_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N_REQ-1:0] grant_oh,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_valid
);

   always_comb begin
      int cand;
      // NOTE: every output gets a default before the loop, so no path through this block can infer a latch.
      cand      = 0;
      grant_oh  = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = (int'(last_grant) + i) % N_REQ;
         if (!any_valid && req_valid[IDX_W'(cand)]) begin
            any_valid               = 1'b1;
            grant_idx               = IDX_W'(cand);
            grant_oh[IDX_W'(cand)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/comp_sched.sv
// Shares one comp datapath among N_REQ requesters: round-robin acceptance,
// one-cycle launch, bounded wait for dv, and a one-hot routed response.
module comp_sched
   import comp_sched_pkg::*;
#(
   parameter int P_SIZE  = 8,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*P_SIZE-1:0]   req_a,
   input  logic [N_REQ*P_SIZE-1:0]   req_b,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [2*P_SIZE-1:0]       rsp_data,
   output logic [2*P_SIZE-1:0]       rsp_data_2,
   output logic                      rsp_err,
   output logic [P_SIZE-1:0]         dp_a,
   output logic [P_SIZE-1:0]         dp_b,
   output logic                      dp_ena,
   input  logic [2*P_SIZE-1:0]       dp_o,
   input  logic [2*P_SIZE-1:0]       dp_o_2,
   input  logic                      dp_dv,
   output logic                      stray_dv
);

   localparam int                IDX_W     = idx_width(N_REQ);
   localparam int                CNT_W     = 8;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(N_REQ - 1);

   state_t               state, state_d;
   logic                 accepted, accepted_d;
   logic [IDX_W-1:0]     grant, grant_d;
   logic [IDX_W-1:0]     last_grant, last_grant_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [N_REQ-1:0]     req_ready_d, rsp_valid_d;
   logic [2*P_SIZE-1:0]  rsp_data_d, rsp_data_2_d;
   logic                 rsp_err_d, dp_ena_d, stray_dv_d;
   logic [P_SIZE-1:0]    dp_a_d, dp_b_d;

   logic [N_REQ-1:0]     pick_oh;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic                 timed_out;

   comp_sched_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
      .req_valid (req_valid),
      .last_grant(last_grant),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any_valid (pick_any)
   );

   assign timed_out = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state      <= S_IDLE;
         accepted   <= 1'b0;
         grant      <= '0;
         last_grant <= LAST_INIT;
         cnt        <= '0;
         req_ready  <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         rsp_data_2 <= '0;
         rsp_err    <= 1'b0;
         dp_a       <= '0;
         dp_b       <= '0;
         dp_ena     <= 1'b0;
         stray_dv   <= 1'b0;
      end else begin
         state      <= state_d;
         accepted   <= accepted_d;
         grant      <= grant_d;
         last_grant <= last_grant_d;
         cnt        <= cnt_d;
         req_ready  <= req_ready_d;
         rsp_valid  <= rsp_valid_d;
         rsp_data   <= rsp_data_d;
         rsp_data_2 <= rsp_data_2_d;
         rsp_err    <= rsp_err_d;
         dp_a       <= dp_a_d;
         dp_b       <= dp_b_d;
         dp_ena     <= dp_ena_d;
         stray_dv   <= stray_dv_d;
      end
   end

   // IDLE spans the pick cycle and the following req_ready cycle, so dp_ena
   // lands one cycle after the acceptance pulse.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (accepted) state_d = S_ISSUE;
         S_ISSUE: state_d = dp_dv ? S_RESP : S_WAIT;
         S_WAIT:  if (dp_dv || timed_out) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      accepted_d   = 1'b0;
      grant_d      = grant;
      last_grant_d = last_grant;
      cnt_d        = cnt;
      req_ready_d  = '0;
      rsp_valid_d  = '0;
      rsp_data_d   = rsp_data;
      rsp_data_2_d = rsp_data_2;
      rsp_err_d    = rsp_err;
      dp_a_d       = dp_a;
      dp_b_d       = dp_b;
      dp_ena_d     = 1'b0;
      stray_dv_d   = stray_dv;
      case (state)
         S_IDLE: begin
            if (dp_dv) stray_dv_d = 1'b1;
            if (accepted) begin
               dp_ena_d = 1'b1;
            end else if (pick_any) begin
               accepted_d  = 1'b1;
               grant_d     = pick_idx;
               req_ready_d = pick_oh;
               dp_a_d      = req_a[pick_idx*P_SIZE +: P_SIZE];
               dp_b_d      = req_b[pick_idx*P_SIZE +: P_SIZE];
            end
         end
         S_ISSUE: begin
            cnt_d = '0;
            if (dp_dv) begin
               rsp_valid_d[grant] = 1'b1;
               rsp_data_d         = dp_o;
               rsp_data_2_d       = dp_o_2;
               rsp_err_d          = 1'b0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt + 1'b1;
            if (dp_dv) begin
               rsp_valid_d[grant] = 1'b1;
               rsp_data_d         = dp_o;
               rsp_data_2_d       = dp_o_2;
               rsp_err_d          = 1'b0;
            end else if (timed_out) begin
               rsp_valid_d[grant] = 1'b1;
               rsp_data_d         = '0;
               rsp_data_2_d       = '0;
               rsp_err_d          = 1'b1;
            end
         end
         S_RESP: begin
            if (dp_dv) stray_dv_d = 1'b1;
            last_grant_d = grant;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_comp_sched.sv
// Self-checking bench for comp_sched: the bench plays the comp datapath
// (product / concatenation with a programmable dv delay) and the requesters.
module tb_comp_sched;

   localparam int P_SIZE  = 8;
   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 15;
   localparam int MAXWAIT = 40;

   logic                    clk;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*P_SIZE-1:0] req_a, req_b;
   logic [N_REQ-1:0]        req_ready, rsp_valid;
   logic [2*P_SIZE-1:0]     rsp_data, rsp_data_2;
   logic                    rsp_err;
   logic [P_SIZE-1:0]       dp_a, dp_b;
   logic                    dp_ena;
   logic [2*P_SIZE-1:0]     dp_o, dp_o_2;
   logic                    dp_dv;
   logic                    stray_dv;

   int checks   = 0;
   int failures = 0;
   int m_last   = N_REQ - 1;

   // Datapath model: k = cycles from dp_ena to dv, k < 0 means dv never comes.
   int   cfg_k = 0;
   logic busy;
   int   cnt_k;
   logic inj_dv;

   comp_sched #(.P_SIZE(P_SIZE), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_data_2(rsp_data_2), .rsp_err(rsp_err),
      .dp_a(dp_a), .dp_b(dp_b), .dp_ena(dp_ena),
      .dp_o(dp_o), .dp_o_2(dp_o_2), .dp_dv(dp_dv),
      .stray_dv(stray_dv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dp_o   = 16'(dp_a) * 16'(dp_b);
   assign dp_o_2 = {dp_a, dp_b};
   assign dp_dv  = (dp_ena && cfg_k == 0) || (busy && cnt_k == cfg_k) || inj_dv;

   always @(posedge clk) begin
      if (rst) begin
         busy  <= 1'b0;
         cnt_k <= 0;
      end else if (dp_ena) begin
         busy  <= (cfg_k > 0);
         cnt_k <= 1;
      end else if (busy) begin
         if (cnt_k == cfg_k) busy <= 1'b0;
         cnt_k <= cnt_k + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Round-robin reference: the winner is the requester closest after last.
   function automatic int model_pick(input logic [N_REQ-1:0] mask, input int last);
      int best, best_d, d;
      best   = -1;
      best_d = N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
         d = (j - last - 1 + 2 * N_REQ) % N_REQ;
         if (mask[j] && d < best_d) begin
            best_d = d;
            best   = j;
         end
      end
      return best;
   endfunction

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_last = N_REQ - 1;
   endtask

   // Drives one request, follows it to its response, and checks timing and data.
   task automatic run_txn(input string tag, input logic [N_REQ-1:0] mask,
                          input logic [N_REQ*P_SIZE-1:0] ops_a, input logic [N_REQ*P_SIZE-1:0] ops_b,
                          input int k, input int exp_g, input int exp_lat, input logic exp_err,
                          input logic [15:0] exp_d, input logic [15:0] exp_d2);
      int  n;
      bit  seen;
      req_valid = mask;
      req_a     = ops_a;
      req_b     = ops_b;
      cfg_k     = k;
      seen      = 0;
      for (n = 0; n < MAXWAIT; n++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL %s accept_timeout: no req_ready within %0d cycles", tag, MAXWAIT);
         req_valid = '0;
         return;
      end
      check({tag, " grant"}, 64'(req_ready), 64'd1 << exp_g);
      check({tag, " ena_at_T"}, 64'(dp_ena), 64'd0);
      req_valid = '0;
      seen = 0;
      for (n = 1; n <= MAXWAIT; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check({tag, " ena_at_T1"}, 64'(dp_ena), 64'd1);
            check({tag, " dp_a"}, 64'(dp_a), 64'(ops_a[exp_g*P_SIZE +: P_SIZE]));
            check({tag, " dp_b"}, 64'(dp_b), 64'(ops_b[exp_g*P_SIZE +: P_SIZE]));
         end
         if (rsp_valid != '0) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL %s rsp_timeout: no rsp_valid within %0d cycles", tag, MAXWAIT);
         return;
      end
      check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1 << exp_g);
      check({tag, " latency"}, 64'(n), 64'(exp_lat));
      check({tag, " rsp_data"}, 64'(rsp_data), 64'(exp_d));
      check({tag, " rsp_data_2"}, 64'(rsp_data_2), 64'(exp_d2));
      check({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
      m_last = exp_g;
   endtask

   typedef struct {
      logic [N_REQ-1:0] mask;
      int               k;
      int               a;
      int               b;
      int               grant;
      int               lat;
      logic             err;
      logic [15:0]      data;
      logic [15:0]      data2;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [N_REQ*P_SIZE-1:0] oa, ob;
      logic [N_REQ-1:0]        mask;
      int                      k, g, lat, rsp_seen, r;
      logic [7:0]              a8, b8;

      vecs[0] = '{4'b0001,  2,   3,   5, 0,  4, 1'b0, 16'd15,   16'h0305};
      vecs[1] = '{4'b1111,  1,  10,  20, 1,  3, 1'b0, 16'd200,  16'h0A14};
      vecs[2] = '{4'b1111,  0, 255, 255, 2,  2, 1'b0, 16'hFE01, 16'hFFFF};
      vecs[3] = '{4'b1111,  3,  16,  16, 3,  5, 1'b0, 16'h0100, 16'h1010};
      vecs[4] = '{4'b1111,  1,   7,   9, 0,  3, 1'b0, 16'h003F, 16'h0709};
      vecs[5] = '{4'b1010,  0,   0,  99, 1,  2, 1'b0, 16'h0000, 16'h0063};
      vecs[6] = '{4'b1001,  2,  12,  12, 3,  4, 1'b0, 16'h0090, 16'h0C0C};
      vecs[7] = '{4'b0100, -1,  50,  60, 2, 17, 1'b1, 16'h0000, 16'h0000};
      vecs[8] = '{4'b0001,  0,   2, 128, 0,  2, 1'b0, 16'h0100, 16'h0280};

      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; inj_dv = 1'b0; cfg_k = 0;
      repeat (3) @(negedge clk);
      check("reset req_ready", 64'(req_ready), 64'd0);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_data", 64'({rsp_data, rsp_data_2}), 64'd0);
      check("reset rsp_err", 64'(rsp_err), 64'd0);
      check("reset dp_ab", 64'({dp_a, dp_b}), 64'd0);
      check("reset dp_ena", 64'(dp_ena), 64'd0);
      check("reset stray_dv", 64'(stray_dv), 64'd0);
      rst = 1'b0;
      m_last = N_REQ - 1;
      @(negedge clk);

      // Non-granted slices carry different operands so misrouting shows up.
      for (int v = 0; v < 9; v++) begin
         for (int j = 0; j < N_REQ; j++) begin
            oa[j*P_SIZE +: P_SIZE] = (j == vecs[v].grant) ? 8'(vecs[v].a) : 8'(8'hE0 + j);
            ob[j*P_SIZE +: P_SIZE] = (j == vecs[v].grant) ? 8'(vecs[v].b) : 8'(8'h30 + j);
         end
         run_txn($sformatf("vec%0d", v), vecs[v].mask, oa, ob, vecs[v].k, vecs[v].grant,
                 vecs[v].lat, vecs[v].err, vecs[v].data, vecs[v].data2);
      end

      for (int t = 0; t < 150; t++) begin
         mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
         r    = $urandom_range(0, 19);
         k    = (r < 18) ? (r % 6) : -1;
         oa   = $urandom;
         ob   = $urandom;
         g    = model_pick(mask, m_last);
         lat  = (k < 0) ? TIMEOUT + 2 : k + 2;
         a8   = oa[g*P_SIZE +: P_SIZE];
         b8   = ob[g*P_SIZE +: P_SIZE];
         run_txn($sformatf("rnd%0d", t), mask, oa, ob, k, g, lat, k < 0,
                 (k < 0) ? 16'd0 : 16'(a8) * 16'(b8), (k < 0) ? 16'd0 : {a8, b8});
      end
      check("no stray after traffic", 64'(stray_dv), 64'd0);

      // Reset while waiting: no response, ena low, priority back to requester 0.
      req_valid = 4'b0010; cfg_k = -1;
      rsp_seen = 0;
      for (int n = 0; n < MAXWAIT && req_ready == '0; n++) @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      pulse_rst();
      check("rst_wait dp_ena", 64'(dp_ena), 64'd0);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rsp_valid != '0 || dp_ena) rsp_seen++;
      end
      check("rst_wait no response", 64'(rsp_seen), 64'd0);
      oa = 32'h44332211; ob = 32'h88776655;
      run_txn("rst_wait next", 4'b1111, oa, ob, 0, 0, 2, 1'b0, 16'h11 * 16'h55, 16'h1155);

      // Stray dv in IDLE: sticky flag, no response, cleared only by reset.
      @(negedge clk);
      inj_dv = 1'b1;
      @(negedge clk);
      inj_dv = 1'b0;
      rsp_seen = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (rsp_valid != '0 || req_ready != '0) rsp_seen++;
      end
      check("stray set", 64'(stray_dv), 64'd1);
      check("stray no response", 64'(rsp_seen), 64'd0);
      g = model_pick(4'b0100, m_last);
      run_txn("stray txn", 4'b0100, oa, ob, 1, g, 3, 1'b0, 16'h33 * 16'h77, 16'h3377);
      check("stray sticky", 64'(stray_dv), 64'd1);
      pulse_rst();
      check("stray cleared", 64'(stray_dv), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
